lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the core's memory stage and the single-port data memory bus.
- Accepts one access at a time from the core and checks alignment.
- Drives a word-aligned bus request with byte enables and replicated write data, then waits for the acknowledge.
- Extracts the addressed byte lane, applies the load size/sign extension, and returns a one-cycle response.

---
 rtl/lsu_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the core memory stage and a
// single-port data memory bus. One access is in flight at a time.
//
// Flow:
//   IDLE : accept a request and check its size and alignment. A bad request
//          goes straight to RESP with an error. A good one goes to BUS.
//   BUS  : hold a word-aligned request with byte enables and lane-replicated
//          store data until mem_ack arrives, or until the timeout expires.
//   RESP : one-cycle response strobe carrying the extended load data.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   req_valid/req_ready      core request handshake (ready only in IDLE)
//   req_we, req_size         store flag; size 0=b 1=ub 2=h 3=uh 4=w
//   req_addr, req_wdata      byte address and right-aligned store data
//   rsp_valid/rdata/err      response strobe, load data, and error code
//                            (00 ok, 01 misaligned, 10 timeout, 11 bad size)
//   mem_req/we/addr/be/wdata bus request fields, held until mem_ack
//   mem_ack, mem_rdata       bus completion and read word
//
// Every output is a register, so all of them read 0 while reset is held.

module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int NUM_LANES = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Only the fields needed after acceptance are kept here. The word
    // address and store data live in the mem_addr and mem_wdata registers.
    typedef struct packed {
        logic       we;
        logic [2:0] size;
        logic [1:0] off;
    } lsu_req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lsu_req_t         req_q, req_d;

    logic        req_ready_d, rsp_valid_d, mem_req_d, mem_we_d;
    logic [31:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [1:0]  rsp_err_d;
    logic [3:0]  mem_be_d;

    logic [NUM_LANES-1:0]           lane_be;
    logic [NUM_LANES-1:0][7:0]      lane_wd;
    logic                           misaligned;
    logic [31:0]                    sh;
    logic [31:0]                    ld_ext;

    // Per-lane byte-enable and store-byte selection. These are computed
    // from the incoming request and are registered when the request is
    // accepted.
    genvar i;
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
        lsu_lane #(.LANE(i)) u_lane (
            .size   (req_size),
            .off    (req_addr[1:0]),
            .b_byte (req_wdata[7:0]),
            .b_half (req_wdata[8*(i%2) +: 8]),
            .b_word (req_wdata[8*i +: 8]),
            .be     (lane_be[i]),
            .wbyte  (lane_wd[i])
        );
    end

    always_comb begin
        misaligned = 1'b0;
        if ((req_size == 3'd2 || req_size == 3'd3) && req_addr[0])
            misaligned = 1'b1;
        if (req_size == 3'd4 && req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end

    // Load extraction: move the addressed lane down to bit 0, then extend.
    assign sh = mem_rdata >> {req_q.off, 3'b000};

    always_comb begin
        case (req_q.size)
            3'd0:    ld_ext = {{24{sh[7]}}, sh[7:0]};
            3'd1:    ld_ext = {24'h0, sh[7:0]};
            3'd2:    ld_ext = {{16{sh[15]}}, sh[15:0]};
            3'd3:    ld_ext = {16'h0, sh[15:0]};
            default: ld_ext = sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 2'b00;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, size: req_size, off: req_addr[1:0]};
                    if (req_size > 3'd4) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 2'b11;
                    end else if (misaligned) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 2'b01;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wd;
                    end
                end
            end
            BUS: begin
                // The ack is tested first, so an ack in the final counted
                // cycle is treated as a success.
                if (mem_ack) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = req_q.we ? 32'h0 : ld_ext;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 2'b10;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we;
                    mem_addr_d  = mem_addr;
                    mem_be_d    = mem_be;
                    mem_wdata_d = mem_wdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// lsu_lane: byte enable and store byte for one bus lane.
//   size, off : access size and byte offset within the word
//   b_byte    : store byte used for byte accesses (wdata[7:0], every lane)
//   b_half    : store byte used for half accesses (low or high byte of the half)
//   b_word    : store byte used for word accesses (this lane's own byte)
//   be, wbyte : lane enable and lane data
module lsu_lane #(
    parameter int LANE = 0
) (
    input  logic [2:0] size,
    input  logic [1:0] off,
    input  logic [7:0] b_byte,
    input  logic [7:0] b_half,
    input  logic [7:0] b_word,
    output logic       be,
    output logic [7:0] wbyte
);

    localparam logic [1:0] L = 2'(LANE);

    always_comb begin
        be    = 1'b1;
        wbyte = b_word;
        if (size <= 3'd1) begin
            be    = (off == L);
            wbyte = b_byte;
        end else if (size <= 3'd3) begin
            be    = (off[1] == L[1]);
            wbyte = b_half;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl. It runs the listed directed cases, then
// randomized accesses. The expected values come from a behavioural model
// that uses plain arithmetic.
module tb_lsu_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        req_ready, rsp_valid, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [1:0]  rsp_err;
    logic [3:0]  mem_be;

    int total = 0;
    int bad = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model ----
    function automatic logic [1:0] m_err(input int unsigned size, input int unsigned addr);
        if (size > 4) return 2'b11;
        if ((size == 2 || size == 3) && (addr % 2) != 0) return 2'b01;
        if (size == 4 && (addr % 4) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input int unsigned size, input int unsigned off);
        if (size <= 1) return 4'(1 << off);
        if (size <= 3) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input int unsigned size, input int unsigned wd);
        if (size <= 1) return (wd % 256) * 32'h0101_0101;
        if (size <= 3) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input int unsigned size, input int unsigned off,
                                         input int unsigned word);
        int unsigned v, b, h;
        v = word / (1 << (8 * off));
        b = v % 256;
        h = v % 65536;
        case (size)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return b;
            2: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3: return h;
            default: return v;
        endcase
    endfunction

    // Drive one access and check every cycle until it returns to IDLE.
    // A value of ack_at in 0..TO-1 is the BUS cycle that gets mem_ack.
    // Any other value means no ack is given.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        logic [1:0]  e;
        logic [31:0] exp_rd;
        int          n;
        logic        acked;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before", 32'(req_ready), 1);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom % 2; req_addr = $urandom; req_wdata = $urandom;
        chk("ready_busy", 32'(req_ready), 0);
        e = m_err(size, addr);
        if (e != 2'b00) begin
            chk("err_valid", 32'(rsp_valid), 1);
            chk("err_code", 32'(rsp_err), 32'(e));
            chk("err_rdata", rsp_rdata, 0);
            chk("err_nomem", 32'(mem_req), 0);
        end else begin
            acked = 1'b0;
            n = 0;
            while (!acked && n < TO) begin
                chk("bus_req", 32'(mem_req), 1);
                chk("bus_we", 32'(mem_we), 32'(we));
                chk("bus_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("bus_be", 32'(mem_be), 32'(m_be(size, addr % 4)));
                chk("bus_wdata", mem_wdata, m_wd(size, wd));
                chk("bus_norsp", 32'(rsp_valid), 0);
                if (n == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
                n++;
            end
            exp_rd = (acked && !we) ? m_rd(size, addr % 4, rd) : 32'h0;
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_err", 32'(rsp_err), acked ? 0 : 2);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_memoff", 32'(mem_req), 0);
        end
        @(negedge clk);
        chk("rsp_once", 32'(rsp_valid), 0);
        chk("ready_after", 32'(req_ready), 1);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_mreq", 32'(mem_req), 0);
        chk("rst_rsp", 32'(rsp_valid), 0);
        chk("rst_be", 32'(mem_be), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_post_rst", 32'(req_ready), 1);

        // directed cases
        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        access(1'b0, 3'd3, 32'h102, 32'h0, 32'hBEEF_0000, 3);
        access(1'b0, 3'd2, 32'h102, 32'h0, 32'hBEEF_0000, 3);
        access(1'b1, 3'd2, 32'h206, 32'h0000_A55A, 32'h1234_5678, 1);
        access(1'b0, 3'd4, 32'h301, 32'h0, 32'h0, 0);
        access(1'b0, 3'd5, 32'h300, 32'h0, 32'h0, 0);
        access(1'b1, 3'd7, 32'h303, 32'h0, 32'h0, 0);
        access(1'b0, 3'd4, 32'h400, 32'h0, 32'hCAFE_F00D, -1);
        access(1'b0, 3'd4, 32'h400, 32'h0, 32'hCAFE_F00D, TO - 1);

        // reset in the middle of a bus access
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'd4; req_addr = 32'h500;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_bus_req", 32'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mreq", 32'(mem_req), 0);
        chk("async_addr", mem_addr, 0);
        chk("async_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;  // a stray ack while IDLE must be ignored
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_norsp", 32'(rsp_valid), 0);
            chk("stray_nomreq", 32'(mem_req), 0);
            chk("stray_ready", 32'(req_ready), 1);
        end
        mem_ack = 1'b0;
        access(1'b0, 3'd1, 32'h601, 32'h0, 32'h0000_9A00, 2);

        // randomized accesses
        for (int t = 0; t < 150; t++) begin
            int s;
            int a;
            s = $urandom_range(0, 9);
            a = $urandom_range(0, TO);
            access(1'($urandom % 2), 3'(s > 7 ? 4 : s), $urandom, $urandom, $urandom,
                   (a == TO) ? -1 : a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
